// File: rtl/registerfile_pkg.sv
// Shared constants and address helpers for the multi-core register file.
package registerfile_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  function automatic int addr_width(input int d);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

  // The shared window occupies the top `shared` addresses.
  function automatic logic is_shared(input int unsigned addr, input int depth, input int shared);
    return (shared > 0) && (addr >= unsigned'(depth - shared));
  endfunction
endpackage

// File: rtl/multicore_registerfile_regbank.sv
// One private register bank: two bypassed combinational reads, one clocked write, r0 tied to zero.
module regbank import registerfile_pkg::*; #(
  parameter int width = DEFAULT_WIDTH,
  parameter int depth = DEFAULT_DEPTH,
  localparam int AW = addr_width(depth)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             write_enable,
  input  logic [AW-1:0]    write_address,
  input  logic [width-1:0] write_data,
  input  logic [AW-1:0]    read_address_1,
  input  logic [AW-1:0]    read_address_2,
  output logic [width-1:0] read_data_1,
  output logic [width-1:0] read_data_2
);
  logic [width-1:0] mem [depth];
  logic             commit;

  assign commit = write_enable && (write_address != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[write_address] <= write_data;
    end
  end

  // Bypass is masked during reset so every read returns zero while reset_n is low.
  function automatic logic [width-1:0] rd(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (reset_n && commit && (a == write_address)) return write_data;
    return mem[a];
  endfunction

  always_comb begin
    read_data_1 = rd(read_address_1);
    read_data_2 = rd(read_address_2);
  end
endmodule

// File: rtl/multicore_registerfile.sv
// Per-core private banks plus a shared window with fixed-priority (lowest core wins) write arbitration.
module multicore_registerfile import registerfile_pkg::*; #(
  parameter int cores  = 1,
  parameter int width  = DEFAULT_WIDTH,
  parameter int depth  = DEFAULT_DEPTH,
  parameter int shared = 0,
  localparam int AW = addr_width(depth)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [cores-1:0]             write_enable,
  input  logic [cores-1:0][AW-1:0]     write_address,
  input  logic [cores-1:0][width-1:0]  write_data,
  input  logic [cores-1:0][AW-1:0]     read_address_1,
  input  logic [cores-1:0][AW-1:0]     read_address_2,
  output logic [cores-1:0][width-1:0]  read_data_1,
  output logic [cores-1:0][width-1:0]  read_data_2,
  output logic [cores-1:0]             write_conflict
);
  logic [cores-1:0]            sh_req, priv_we;
  logic [cores-1:0][width-1:0] bank_rd_1, bank_rd_2;
  logic [depth-1:0]            sh_we;
  logic [depth-1:0][width-1:0] sh_wd;
  logic [width-1:0]            sh_mem [depth];

  always_comb begin
    for (int c = 0; c < cores; c++) begin
      sh_req[c]  = write_enable[c] &&  is_shared(32'(write_address[c]), depth, shared);
      priv_we[c] = write_enable[c] && !is_shared(32'(write_address[c]), depth, shared);
    end
  end

  for (genvar c = 0; c < cores; c++) begin : g_bank
    regbank #(.width(width), .depth(depth)) u_bank (
      .clk            (clk),
      .reset_n        (reset_n),
      .write_enable   (priv_we[c]),
      .write_address  (write_address[c]),
      .write_data     (write_data[c]),
      .read_address_1 (read_address_1[c]),
      .read_address_2 (read_address_2[c]),
      .read_data_1    (bank_rd_1[c]),
      .read_data_2    (bank_rd_2[c])
    );
  end

  // Walk from the highest core down so the lowest requester overwrites last and wins.
  always_comb begin
    sh_we = '0;
    sh_wd = '0;
    for (int c = cores - 1; c >= 0; c--) begin
      if (sh_req[c]) begin
        sh_we[write_address[c]] = 1'b1;
        sh_wd[write_address[c]] = write_data[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < depth; i++) sh_mem[i] <= '0;
    end else begin
      for (int i = 0; i < depth; i++) if (sh_we[i]) sh_mem[i] <= sh_wd[i];
    end
  end

  function automatic logic [width-1:0] sh_rd(input logic [AW-1:0] a);
    return (reset_n && sh_we[a]) ? sh_wd[a] : sh_mem[a];
  endfunction

  always_comb begin
    for (int c = 0; c < cores; c++) begin
      read_data_1[c] = is_shared(32'(read_address_1[c]), depth, shared) ? sh_rd(read_address_1[c]) : bank_rd_1[c];
      read_data_2[c] = is_shared(32'(read_address_2[c]), depth, shared) ? sh_rd(read_address_2[c]) : bank_rd_2[c];
    end
  end

  if (cores == 1) begin : g_single
    assign write_conflict = '0;
  end else begin : g_arb
    logic [cores-1:0] lose;

    // A core loses when any lower-index core targets the same shared address this cycle.
    always_comb begin
      lose = '0;
      for (int c = 1; c < cores; c++)
        for (int j = 0; j < c; j++)
          if (sh_req[c] && sh_req[j] && (write_address[c] == write_address[j])) lose[c] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) write_conflict <= '0;
      else          write_conflict <= lose;
    end
  end
endmodule

// File: tb/tb_multicore_registerfile.sv
// Randomized and directed check of multicore_registerfile against an array-based reference model.
module tb_multicore_registerfile;
  localparam int C = 4, W = 32, D = 32, S = 4, AW = 5;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [C-1:0]         we, wc;
  logic [C-1:0][AW-1:0] wa, ra1, ra2;
  logic [C-1:0][W-1:0]  wd, rd1, rd2;
  logic [0:0]           s_we, s_wc;
  logic [0:0][AW-1:0]   s_wa, s_ra1, s_ra2;
  logic [0:0][W-1:0]    s_wd, s_rd1, s_rd2;

  logic [W-1:0] m_priv [C][D];
  logic [W-1:0] m_shr  [D];
  logic [C-1:0] exp_wc;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  multicore_registerfile #(.cores(C), .width(W), .depth(D), .shared(S)) u_dut (
    .clk(clk), .reset_n(reset_n), .write_enable(we), .write_address(wa), .write_data(wd),
    .read_address_1(ra1), .read_address_2(ra2), .read_data_1(rd1), .read_data_2(rd2),
    .write_conflict(wc));

  multicore_registerfile #(.cores(1), .width(W), .depth(D), .shared(0)) u_single (
    .clk(clk), .reset_n(reset_n), .write_enable(s_we), .write_address(s_wa), .write_data(s_wd),
    .read_address_1(s_ra1), .read_address_2(s_ra2), .read_data_1(s_rd1), .read_data_2(s_rd2),
    .write_conflict(s_wc));

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference read: what the register will hold after the next edge, or what it holds now.
  function automatic logic [W-1:0] model_rd(input int c, input int a);
    if (!reset_n || a == 0) return '0;
    if (a >= D - S) begin
      for (int j = 0; j < C; j++) if (we[j] && int'(wa[j]) == a) return wd[j];
      return m_shr[a];
    end
    if (we[c] && int'(wa[c]) == a) return wd[c];
    return m_priv[c][a];
  endfunction

  task automatic check_reads(input string tag);
    for (int c = 0; c < C; c++) begin
      chk($sformatf("%s rd1 c%0d a%0d", tag, c, ra1[c]), rd1[c], model_rd(c, int'(ra1[c])));
      chk($sformatf("%s rd2 c%0d a%0d", tag, c, ra2[c]), rd2[c], model_rd(c, int'(ra2[c])));
    end
  endtask

  task automatic clear_in();
    we = '0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    s_we = '0; s_wa = '0; s_wd = '0; s_ra1 = '0; s_ra2 = '0;
  endtask

  task automatic zero_model();
    for (int a = 0; a < D; a++) begin
      m_shr[a] = '0;
      for (int c = 0; c < C; c++) m_priv[c][a] = '0;
    end
  endtask

  task automatic tick();
    logic [C-1:0] nxt;
    nxt = '0;
    if (reset_n) begin
      for (int c = 0; c < C; c++)
        if (we[c] && int'(wa[c]) >= D - S)
          for (int j = 0; j < c; j++) if (we[j] && wa[j] == wa[c]) nxt[c] = 1'b1;
      for (int c = 0; c < C; c++)
        if (we[c] && wa[c] != '0 && int'(wa[c]) < D - S) m_priv[c][wa[c]] = wd[c];
      for (int a = D - S; a < D; a++)
        for (int c = 0; c < C; c++)
          if (we[c] && int'(wa[c]) == a) begin m_shr[a] = wd[c]; break; end
    end
    exp_wc = nxt;
    @(posedge clk); #1;
    chk("conflict", 32'(wc), 32'(exp_wc));
    chk("single conflict", 32'(s_wc), 32'd0);
  endtask

  function automatic logic [AW-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return AW'($urandom_range(0, D - 1));
      1:       return AW'($urandom_range(0, 3));
      default: return AW'($urandom_range(D - S, D - 1));
    endcase
  endfunction

  initial begin
    clear_in(); zero_model(); exp_wc = '0;
    repeat (2) @(posedge clk);
    #1;
    ra1[2] = 5'd5; ra2[3] = 5'd30; #1;
    check_reads("reset");
    chk("reset wc", 32'(wc), 32'd0);
    reset_n = 1'b1;

    // private isolation
    clear_in();
    we = 4'b0011; wa[0] = 5'd15; wd[0] = 32'h15; wa[1] = 5'd15; wd[1] = 32'hAA;
    for (int c = 0; c < C; c++) begin ra1[c] = 5'd15; ra2[c] = 5'd15; end
    #1; check_reads("iso byp");
    tick(); we = '0; #1;
    chk("iso c0", rd1[0], 32'h15); chk("iso c1", rd1[1], 32'hAA);
    chk("iso c2", rd1[2], 32'h0);  chk("iso c3", rd2[3], 32'h0);

    // bypass and r0
    clear_in();
    we[3] = 1'b1; wa[3] = 5'd9; wd[3] = 32'h1234; ra1[3] = 5'd9; ra2[3] = 5'd9;
    we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF;
    #1;
    chk("byp p1", rd1[3], 32'h1234); chk("byp p2", rd2[3], 32'h1234); chk("r0 byp", rd1[0], 32'h0);
    tick(); we = '0; #1;
    chk("byp post p1", rd1[3], 32'h1234); chk("byp post p2", rd2[3], 32'h1234); chk("r0 post", rd2[0], 32'h0);

    // shared collision
    clear_in();
    we = 4'b1110; wa[1] = 5'd30; wa[2] = 5'd30; wa[3] = 5'd30;
    wd[1] = 32'h11; wd[2] = 32'h22; wd[3] = 32'h33;
    for (int c = 0; c < C; c++) begin ra1[c] = 5'd30; ra2[c] = 5'd30; end
    #1;
    for (int c = 0; c < C; c++) chk($sformatf("sh byp c%0d", c), rd1[c], 32'h11);
    tick();
    chk("sh wc pulse", 32'(wc), 32'hC);
    we = '0; #1;
    for (int c = 0; c < C; c++) chk($sformatf("sh post c%0d", c), rd2[c], 32'h11);
    tick();
    chk("sh wc clear", 32'(wc), 32'h0);

    // disabled write
    clear_in();
    wa[0] = 5'd15; wd[0] = 32'h1F; ra1[0] = 5'd15;
    tick(); #1;
    chk("disabled", rd1[0], 32'h15);

    // reset mid-pulse, then writes during reset are dropped
    clear_in();
    we = 4'b0111; wa[2] = 5'd5; wd[2] = 32'hDEADBEEF;
    wa[0] = 5'd29; wd[0] = 32'h1; wa[1] = 5'd29; wd[1] = 32'h2;
    tick();
    chk("rst pre wc", 32'(wc), 32'h2);
    clear_in(); ra1[2] = 5'd5; #1;
    chk("rst pre r5", rd1[2], 32'hDEADBEEF);
    reset_n = 1'b0; #1;
    chk("rst r5", rd1[2], 32'h0);
    chk("rst wc", 32'(wc), 32'h0);
    zero_model();
    we[2] = 1'b1; wa[2] = 5'd5; wd[2] = 32'h77; #1;
    chk("rst byp", rd1[2], 32'h0);
    tick();
    reset_n = 1'b1;
    clear_in(); ra1[2] = 5'd5; #1;
    chk("rst discard", rd1[2], 32'h0);

    // single-core build
    clear_in();
    s_we[0] = 1'b1; s_wa[0] = 5'd9;  s_wd[0] = 32'h1;  tick();
    s_wa[0] = 5'd15; s_wd[0] = 32'hD;  tick();
    s_wa[0] = 5'd27; s_wd[0] = 32'h19; tick();
    s_we[0] = 1'b0; s_ra1[0] = 5'd9; s_ra2[0] = 5'd27; #1;
    chk("single r9", s_rd1[0], 32'h1);
    chk("single r27", s_rd2[0], 32'h19);
    s_ra1[0] = 5'd15; #1;
    chk("single r15", s_rd1[0], 32'hD);

    // randomized traffic with occasional asynchronous reset
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 49) == 0) begin
        clear_in(); reset_n = 1'b0; #1;
        zero_model(); exp_wc = '0;
        check_reads("rnd rst");
        chk("rnd rst wc", 32'(wc), 32'h0);
        reset_n = 1'b1;
      end
      for (int c = 0; c < C; c++) begin
        we[c] = 1'($urandom_range(0, 1)); wa[c] = pick(); wd[c] = $urandom;
        ra1[c] = pick(); ra2[c] = pick();
      end
      #1; check_reads("rnd");
      tick();
    end
    clear_in(); #1;
    check_reads("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
